vc_test_src_arbiter: RTL and testbench
======================================

// Module: vc_test_src_arbiter
// PURPOSE
//  Shares one val/rdy sink channel between p_nreqs random-delay test sources.
//  Round-robin arbitration; a grant is held until its message transfers.
//  Tags each message with its source id and counts transfers per source.
//  Aggregates the sources' done flags into one harness-level all_done.
// PARAMETERS
//  p_nreqs      4    number of requesting sources (2..16)
//  p_msg_nbits  32   message width
//  p_cnt_nbits  16   width of each per-source transfer counter
//  (derived) c_id_nbits = clog2(p_nreqs), min 1
// PORTS
//  clk        in   1                      clock
//  reset      in   1                      synchronous, active-high
//  in_val     in   p_nreqs                per-source valid
//  in_rdy     out  p_nreqs                per-source ready (one-hot or zero)
//  in_msg     in   p_nreqs*p_msg_nbits    source i at bits [i*W +: W]
//  src_done   in   p_nreqs                per-source done
//  out_val    out  1                      arbitrated valid
//  out_rdy    in   1                      sink ready
//  out_msg    out  p_msg_nbits            granted source's message
//  out_id     out  c_id_nbits             granted source index
//  xfer_cnt   out  p_nreqs*p_cnt_nbits    per-source transfer counts
//  all_done   out  1                      all sources done, channel drained
// BEHAVIOUR
//  - Reset (sync, high): ptr=0, lock=0, lock_id=0, xfer_cnt=0, all_done=0.
//    in_rdy=0 and out_val=0 in the reset cycle regardless of in_val.
//  - State UNLOCKED (lock=0): grant = first i with in_val[i], scanning
//    ptr, ptr+1, ..., wrapping mod p_nreqs. Combinational; 0-cycle latency.
//    out_val=|in_val; out_msg/out_id from grant; in_rdy[grant]=out_rdy.
//  - UNLOCKED & out_val & !out_rdy -> LOCKED, lock_id=grant.
//  - State LOCKED: grant forced to lock_id; other in_val ignored. A new
//    higher-priority request must not change out_msg/out_id (val/rdy stability).
//  - Transfer = out_val & out_rdy: state -> UNLOCKED;
//    ptr <= (grant==p_nreqs-1) ? 0 : grant+1;
//    xfer_cnt[grant]++, wrapping at 2^p_cnt_nbits.
//  - No transfer: ptr unchanged. in_val dropping while LOCKED is a source
//    protocol error: out_val follows in_val[lock_id]; lock is kept.
//  - Single requester: granted every cycle it is valid, 1 msg/cycle throughput.
//  - all_done registered: next = &src_done & ~|in_val & ~lock. Once high it
//    stays high until reset.
//  - Reset mid-transfer: lock cleared, the message is not counted, and no
//    in_rdy is asserted in that cycle.
// CONFIGURATION
//  VC_TEST_SRC_ARBITER_TRACE_EN
//   defined:     trace_module task emits per-cycle "id:msg" via
//                vc_trace_str_val_rdy, plus '#' when LOCKED.
//   not defined: no trace task, no trace regs. Port list and behaviour are
//                identical.
// STRUCTURE
//  - Shared header vc-test-src-arbiter-defs.v:
//    VC_TEST_SRC_ARBITER_MAX_REQS=16, state encodings UNLOCKED=0/LOCKED=1,
//    and the clog2 id-width macro.
//  - Sub-module vc_rr_prio_sel:
//    inputs req[p_nreqs], ptr; outputs grant_id, grant_val.
//    Purely combinational rotate-and-priority-encode.
//    Lock, ptr, counters and all_done live in the top.
// TESTING
//  1 p_nreqs=4, in_val=1111, out_rdy=1 for 8 cycles -> out_id 0,1,2,3,0,1,2,3;
//    xfer_cnt=2 each.
//  2 in_val=0101, out_rdy=0 for 3 cycles then 1 -> out_id stays 0 and out_msg
//    stays constant while stalled; next grant is 2.
//  3 LOCKED on id 2 with ptr=2; raise in_val[1] -> out_id stays 2 until the
//    transfer; in_rdy[1]=0 throughout.
//  4 Only src 3 valid, out_rdy=1 for 5 cycles -> 5 transfers, xfer_cnt[3]=5,
//    ptr=0 after each.
//  5 src_done=1111, no in_val, unlocked -> all_done=1 one cycle later;
//    src_done=1111 while LOCKED -> all_done stays 0 until the transfer.
//  6 Assert reset while LOCKED with out_rdy=1 -> no count increment; next
//    cycle ptr=0, lock=0, all outputs at reset values.

Source files
------------

// File: rtl/vc_test_src_arbiter_pkg.sv
// Shared definitions for the test-source arbiter: request limit, lock state
// encoding and the source-id width helper.
package vc_test_src_arbiter_pkg;

  // Largest number of sources the arbiter is intended to serve.
  localparam int VC_TEST_SRC_ARBITER_MAX_REQS = 16;

  // Grant lock state: UNLOCKED arbitrates freely, LOCKED holds a stalled grant.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_e;

  // Width of a source index; never narrower than one bit.
  function automatic int id_nbits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vc_test_src_arbiter_if.sv
// Harness-side bundle of the arbiter: per-source val/rdy/msg/done, the shared
// sink channel, per-source transfer counters and the aggregated done flag.
// The slave modport is the arbiter; the master modport is the harness.
interface vc_test_src_arbiter_if
  import vc_test_src_arbiter_pkg::*;
#(
  parameter int p_nreqs     = 4,
  parameter int p_msg_nbits = 32,
  parameter int p_cnt_nbits = 16
);

  localparam int c_id_nbits = id_nbits(p_nreqs);

  logic [p_nreqs-1:0]             in_val;
  logic [p_nreqs-1:0]             in_rdy;
  logic [p_nreqs*p_msg_nbits-1:0] in_msg;
  logic [p_nreqs-1:0]             src_done;
  logic                           out_val;
  logic                           out_rdy;
  logic [p_msg_nbits-1:0]         out_msg;
  logic [c_id_nbits-1:0]          out_id;
  logic [p_nreqs*p_cnt_nbits-1:0] xfer_cnt;
  logic                           all_done;

  modport slave (
    input  in_val, in_msg, src_done, out_rdy,
    output in_rdy, out_val, out_msg, out_id, xfer_cnt, all_done
  );

  modport master (
    output in_val, in_msg, src_done, out_rdy,
    input  in_rdy, out_val, out_msg, out_id, xfer_cnt, all_done
  );

endinterface

// File: rtl/vc_rr_prio_sel.sv
// Round-robin priority selector: picks the first asserted request starting at
// ptr and wrapping modulo p_nreqs. Purely combinational.
module vc_rr_prio_sel
  import vc_test_src_arbiter_pkg::*;
#(
  parameter int p_nreqs = 4,
  parameter int c_id_nbits = id_nbits(p_nreqs)
)(
  input  logic [p_nreqs-1:0]     req,
  input  logic [c_id_nbits-1:0]  ptr,
  output logic [c_id_nbits-1:0]  grant_id,
  output logic                   grant_val
);

  // Scan ptr, ptr+1, ... wrapping; the first requester found wins.
  always_comb begin
    int                    sum_v;
    logic [c_id_nbits-1:0] idx_v;
    logic                  take_v;
    grant_id  = {c_id_nbits{1'b0}};
    grant_val = 1'b0;
    for (int k = 0; k < p_nreqs; k++) begin
      sum_v     = int'(ptr) + k;
      sum_v     = (sum_v >= p_nreqs) ? (sum_v - p_nreqs) : sum_v;
      idx_v     = c_id_nbits'(sum_v);
      take_v    = ~grant_val & req[idx_v];
      grant_id  = take_v ? idx_v : grant_id;
      grant_val = grant_val | take_v;
    end
  end

endmodule

// File: rtl/vc_test_src_arbiter.sv
// Shares one val/rdy sink between p_nreqs test sources with round-robin
// arbitration. A grant that stalls is locked until its message transfers, so
// out_msg/out_id stay stable. Counts transfers per source and raises a sticky
// all_done once every source is done and the channel is drained.
// Optional build macro VC_TEST_SRC_ARBITER_TRACE_EN adds a trace_module task.
module vc_test_src_arbiter
  import vc_test_src_arbiter_pkg::*;
#(
  parameter int p_nreqs     = 4,
  parameter int p_msg_nbits = 32,
  parameter int p_cnt_nbits = 16
)(
  input  logic                  clk,
  input  logic                  reset,
  vc_test_src_arbiter_if.slave  io
);

  localparam int c_id_nbits = id_nbits(p_nreqs);
  localparam logic [c_id_nbits-1:0] c_last_id = c_id_nbits'(p_nreqs - 1);

  arb_state_e                              state_r;
  logic [c_id_nbits-1:0]                   lock_id_r;
  logic [c_id_nbits-1:0]                   ptr_r;
  logic [p_nreqs-1:0][p_cnt_nbits-1:0]     cnt_r;
  logic                                    all_done_r;

  logic [p_nreqs-1:0][p_msg_nbits-1:0]     msg_arr_s;
  logic [c_id_nbits-1:0]                   sel_id_s;
  logic                                    sel_val_s;
  logic [c_id_nbits-1:0]                   grant_id_s;
  logic                                    grant_val_s;
  logic                                    out_val_s;
  logic                                    xfer_s;
  logic [p_nreqs-1:0]                      in_rdy_s;

  assign msg_arr_s = io.in_msg;

  vc_rr_prio_sel #(
    .p_nreqs    (p_nreqs),
    .c_id_nbits (c_id_nbits)
  ) u_sel (
    .req       (io.in_val),
    .ptr       (ptr_r),
    .grant_id  (sel_id_s),
    .grant_val (sel_val_s)
  );

  // Grant selection: a locked grant overrides the round-robin choice, and
  // outputs are held quiet during reset.
  always_comb begin
    if (state_r == LOCKED) begin
      grant_id_s  = lock_id_r;
      grant_val_s = io.in_val[lock_id_r];
    end else begin
      grant_id_s  = sel_id_s;
      grant_val_s = sel_val_s;
    end
    out_val_s = grant_val_s & ~reset;
    xfer_s    = out_val_s & io.out_rdy;
    in_rdy_s  = {p_nreqs{1'b0}};
    in_rdy_s[grant_id_s] = xfer_s;
  end

  assign io.out_val  = out_val_s;
  assign io.out_msg  = msg_arr_s[grant_id_s];
  assign io.out_id   = grant_id_s;
  assign io.in_rdy   = in_rdy_s;
  assign io.xfer_cnt = cnt_r;
  assign io.all_done = all_done_r;

  // Lock/pointer/counter state and the sticky all_done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= UNLOCKED;
      lock_id_r  <= {c_id_nbits{1'b0}};
      ptr_r      <= {c_id_nbits{1'b0}};
      cnt_r      <= {(p_nreqs*p_cnt_nbits){1'b0}};
      all_done_r <= 1'b0;
    end else begin
      all_done_r <= all_done_r |
                    (&io.src_done & ~(|io.in_val) & (state_r == UNLOCKED));
      if (xfer_s) begin
        state_r           <= UNLOCKED;
        ptr_r             <= (grant_id_s == c_last_id) ? {c_id_nbits{1'b0}}
                                                       : grant_id_s + c_id_nbits'(1'b1);
        cnt_r[grant_id_s] <= cnt_r[grant_id_s] + p_cnt_nbits'(1'b1);
      end else if ((state_r == UNLOCKED) && out_val_s) begin
        state_r   <= LOCKED;
        lock_id_r <= grant_id_s;
      end else begin
        state_r   <= state_r;
        lock_id_r <= lock_id_r;
      end
    end
  end

`ifdef VC_TEST_SRC_ARBITER_TRACE_EN
  logic [31:0] trace_cycle_r;

  // Cycle stamp for trace lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      trace_cycle_r <= 32'd0;
    end else begin
      trace_cycle_r <= trace_cycle_r + 32'd1;
    end
  end

  // Channel view: payload on transfer, '#' on stall, '.' when idle-ready.
  function automatic string vc_trace_str_val_rdy(input logic val, input logic rdy,
                                                 input string str);
    if (val && rdy) begin
      return str;
    end else if (val) begin
      return "#";
    end else if (rdy) begin
      return ".";
    end else begin
      return " ";
    end
  endfunction

  task automatic trace_module(output string trace_str);
    trace_str = $sformatf("%0d %s", trace_cycle_r,
                          vc_trace_str_val_rdy(io.out_val, io.out_rdy,
                            $sformatf("%0d:%h", io.out_id, io.out_msg)));
    if (state_r == LOCKED) begin
      trace_str = {trace_str, "#"};
    end else begin
      trace_str = trace_str;
    end
  endtask
`endif

endmodule

// File: tb/tb_vc_test_src_arbiter.sv
// Directed bench for vc_test_src_arbiter (4 sources, 32-bit msgs, 16-bit counters).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_vc_test_src_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vc_test_src_arbiter_if #(.p_nreqs(4), .p_msg_nbits(32), .p_cnt_nbits(16)) io ();

  vc_test_src_arbiter #(.p_nreqs(4), .p_msg_nbits(32), .p_cnt_nbits(16)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  localparam logic [127:0] c_msgs = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] msg_of(input int id);
    logic [127:0] m;
    m = c_msgs;
    return m[id*32 +: 32];
  endfunction

  // Drive inputs, then check the combinational grant after 1 ns.
  task automatic drive(input logic [3:0] val, input logic rdy);
    io.in_val  = val;
    io.out_rdy = rdy;
    #1;
  endtask

  task automatic check_grant(input string tag, input int id, input logic rdy);
    check_val({tag, "_val"}, 64'(io.out_val), 64'd1);
    check_val({tag, "_id"},  64'(io.out_id),  64'(id));
    check_val({tag, "_msg"}, 64'(io.out_msg), 64'(msg_of(id)));
    check_val({tag, "_rdy"}, 64'(io.in_rdy),  rdy ? 64'(4'b0001 << id) : 64'd0);
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    io.in_msg   = c_msgs;
    io.src_done = 4'b0000;
    @(negedge clk);

    // Reset cycle: outputs quiet regardless of requests.
    drive(4'b1111, 1'b1);
    check_val("rst_out_val", 64'(io.out_val), 64'd0);
    check_val("rst_in_rdy",  64'(io.in_rdy),  64'd0);
    next_cycle();
    check_val("rst_cnt",  64'(io.xfer_cnt), 64'd0);
    check_val("rst_done", 64'(io.all_done), 64'd0);
    reset = 1'b0;

    // 1: all valid, sink always ready -> strict rotation.
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 1'b1);
      check_grant($sformatf("t1_c%0d", k), k % 4, 1'b1);
      next_cycle();
    end
    check_val("t1_cnt", 64'(io.xfer_cnt), 64'h0002_0002_0002_0002);

    // 2: stall on src 0 for three cycles, then release; src 2 follows.
    for (int k = 0; k < 3; k++) begin
      drive(4'b0101, 1'b0);
      check_grant($sformatf("t2_stall%0d", k), 0, 1'b0);
      next_cycle();
    end
    drive(4'b0101, 1'b1);
    check_grant("t2_go0", 0, 1'b1);
    next_cycle();
    drive(4'b0101, 1'b1);
    check_grant("t2_go2", 2, 1'b1);
    next_cycle();

    // 3: src 1 alone moves ptr to 2; lock on src 2, then src 1 requests.
    drive(4'b0010, 1'b1);
    check_grant("t3_src1", 1, 1'b1);
    next_cycle();
    drive(4'b0100, 1'b0);
    check_grant("t3_lock", 2, 1'b0);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      drive(4'b0110, 1'b0);
      check_grant($sformatf("t3_held%0d", k), 2, 1'b0);
      next_cycle();
    end
    drive(4'b0110, 1'b1);
    check_grant("t3_xfer", 2, 1'b1);
    next_cycle();

    // 4: only src 3 valid for five cycles.
    for (int k = 0; k < 5; k++) begin
      drive(4'b1000, 1'b1);
      check_grant($sformatf("t4_c%0d", k), 3, 1'b1);
      next_cycle();
    end
    check_val("t4_cnt3", 64'(io.xfer_cnt[63:48]), 64'd7);
    // ptr must have wrapped to 0: src 0 beats src 3.
    drive(4'b1001, 1'b0);
    check_grant("t4_ptr0", 0, 1'b0);
    next_cycle();
    drive(4'b1001, 1'b1);
    check_grant("t4_xfer0", 0, 1'b1);
    next_cycle();

    // 5: done while locked keeps all_done low until the channel drains.
    io.src_done = 4'b1111;
    drive(4'b0100, 1'b0);
    check_grant("t5_lock", 2, 1'b0);
    next_cycle();
    drive(4'b0000, 1'b0);
    check_val("t5_drop_val", 64'(io.out_val), 64'd0);
    check_val("t5_drop_rdy", 64'(io.in_rdy),  64'd0);
    next_cycle();
    check_val("t5_locked_done", 64'(io.all_done), 64'd0);
    drive(4'b0100, 1'b1);
    check_grant("t5_relock_xfer", 2, 1'b1);
    next_cycle();
    check_val("t5_xfer_done", 64'(io.all_done), 64'd0);
    drive(4'b0000, 1'b0);
    next_cycle();
    check_val("t5_done", 64'(io.all_done), 64'd1);
    check_val("t5_cnt", 64'(io.xfer_cnt), 64'h0007_0005_0003_0004);
    io.src_done = 4'b0000;
    drive(4'b0000, 1'b0);
    next_cycle();
    check_val("t5_sticky", 64'(io.all_done), 64'd1);

    // 6: reset while locked with sink ready.
    drive(4'b0010, 1'b0);
    check_grant("t6_lock", 1, 1'b0);
    next_cycle();
    reset = 1'b1;
    drive(4'b0010, 1'b1);
    check_val("t6_rst_val", 64'(io.out_val), 64'd0);
    check_val("t6_rst_rdy", 64'(io.in_rdy),  64'd0);
    next_cycle();
    reset = 1'b0;
    drive(4'b0000, 1'b0);
    check_val("t6_cnt",  64'(io.xfer_cnt), 64'd0);
    check_val("t6_done", 64'(io.all_done), 64'd0);
    check_val("t6_val",  64'(io.out_val),  64'd0);
    drive(4'b1001, 1'b0);
    check_grant("t6_unlocked_ptr0", 0, 1'b0);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
